alu_issue_stage: RTL and testbench

Command-issue and result-capture stage wrapped around the 8-bit combinational ALU (4-bit `sel`, operands `a`/`b`, carry-in `cin`, result `y`). It buffers incoming commands in a 4-deep FIFO and holds an 8-bit accumulator that drives ALU operand `a`. It drives the ALU inputs from the FIFO head, captures `y` into the accumulator and a registered result port with valid/ready backpressure. It sits directly upstream of the ALU, and its own downstream is the result consumer.

---
 rtl/alu_issue_stage.sv | 141 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Command-issue / result-capture stage in front of the 8-bit combinational ALU.
// Optional ALU_ISSUE_ZFLAG_EN adds a registered res_zero flag next to res_data.
module alu_issue_stage #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_cin,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] acc
`ifdef ALU_ISSUE_ZFLAG_EN
    ,
    output logic       res_zero
`endif
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] data;
        logic       cin;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_STALL
    } state_t;

    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_acc;
    logic [7:0]       r_res_data;
    logic             r_res_valid;

    cmd_t   w_head;
    logic   w_empty;
    logic   w_full;
    logic   w_push;
    logic   w_pop;
    logic   w_exec_load;
    logic   w_exec_alu;
    state_t w_state;

    // Pointer MSB separates full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Per-cycle issue decision from registered occupancy and the head entry.
    always_comb begin
        w_state = ST_IDLE;
        if (!w_empty) begin
            if (w_head.op[4] || !r_res_valid || res_ready) begin
                w_state = ST_EXEC;
            end else begin
                w_state = ST_STALL;
            end
        end
    end

    assign w_push      = cmd_valid && !w_full;
    assign w_pop       = (w_state == ST_EXEC);
    assign w_exec_load = w_pop &&  w_head.op[4];
    assign w_exec_alu  = w_pop && !w_head.op[4];

    assign cmd_ready = !w_full;
    assign alu_a     = r_acc;
    assign alu_b     = w_empty ? 8'h00 : w_head.data;
    assign alu_cin   = w_empty ? 1'b0  : w_head.cin;
    assign alu_sel   = w_empty ? 4'h0  : w_head.op[3:0];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign acc       = r_acc;

    // Command storage; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= '{op: cmd_op, data: cmd_data, cin: cmd_cin};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_acc       <= 8'h00;
            r_res_data  <= 8'h00;
            r_res_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_exec_load) begin
                r_acc <= w_head.data;
            end else if (w_exec_alu) begin
                r_acc <= alu_y;
            end
            // A same-cycle ALU result overrides the consumer handshake.
            if (w_exec_alu) begin
                r_res_data  <= alu_y;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_ZFLAG_EN
    logic r_res_zero;

    assign res_zero = r_res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_zero <= 1'b0;
        end else if (w_exec_alu) begin
            r_res_zero <= (alu_y == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU on alu_y.
// Define ALU_ISSUE_ZFLAG_EN to also exercise res_zero.
module tb_alu_issue_stage;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_cin;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_sel;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] acc;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic       res_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_stage #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cin   (cmd_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .acc       (acc)
`ifdef ALU_ISSUE_ZFLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subset of the ALU opcodes used by the vectors below.
    always_comb begin
        case (alu_sel)
            4'h1:    alu_y = 8'(alu_a + 8'd1);
            4'h2:    alu_y = 8'(alu_a - 8'd1);
            4'h6:    alu_y = 8'(alu_a + alu_b);
            4'h7:    alu_y = 8'(alu_a + alu_b + {7'd0, alu_cin});
            4'hA:    alu_y = alu_a & alu_b;
            default: alu_y = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [7:0] d, input logic c);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cin   = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b1;
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data",  32'(res_data),  32'h00);
        check("rst_acc",       32'(acc),       32'h00);
        check("rst_alu_a",     32'(alu_a),     32'h00);
        check("rst_alu_b",     32'(alu_b),     32'h00);
        check("rst_alu_sel",   32'(alu_sel),   32'h0);
        check("rst_alu_cin",   32'(alu_cin),   32'h0);
`ifdef ALU_ISSUE_ZFLAG_EN
        check("rst_res_zero",  32'(res_zero),  32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // LOAD 0x10 then a+b with b=0x05
        drive(1'b1, 5'h10, 8'h10, 1'b0);
        tick();
        drive(1'b1, 5'h06, 8'h05, 1'b0);
        tick();
        check("load_acc",       32'(acc),       32'h10);
        check("load_no_result", 32'(res_valid), 32'h0);
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        check("add_valid", 32'(res_valid), 32'h1);
        check("add_data",  32'(res_data),  32'h15);
        check("add_acc",   32'(acc),       32'h15);

        // a+b+cin wrap-around, then a&b, back to back
        drive(1'b1, 5'h07, 8'hFF, 1'b1);
        tick();
        check("consumed", 32'(res_valid), 32'h0);
        drive(1'b1, 5'h0A, 8'h0F, 1'b0);
        tick();
        check("adc_wrap_data", 32'(res_data), 32'h15);
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        check("and_data",  32'(res_data),  32'h05);
        check("and_acc",   32'(acc),       32'h05);
        check("and_valid", 32'(res_valid), 32'h1);
        tick();
        check("idle_valid_clr", 32'(res_valid), 32'h0);

        // Backpressure: six a+1 commands from acc=0 with consumer stalled
        res_ready = 1'b0;
        drive(1'b1, 5'h10, 8'h00, 1'b0);
        tick();
        drive(1'b1, 5'h01, 8'h00, 1'b0);
        tick();
        check("bp_acc0", 32'(acc), 32'h00);
        tick();
        check("bp_first_valid", 32'(res_valid), 32'h1);
        check("bp_first_data",  32'(res_data),  32'h01);
        tick();
        tick();
        tick();
        check("bp_full_ready", 32'(cmd_ready), 32'h0);
        tick();
        check("bp_sixth_wait",  32'(cmd_ready), 32'h0);
        check("bp_hold_data",   32'(res_data),  32'h01);
        check("bp_hold_valid",  32'(res_valid), 32'h1);
        check("bp_hold_sel",    32'(alu_sel),   32'h1);
        res_ready = 1'b1;
        tick();
        check("bp_res2",      32'(res_data),  32'h02);
        check("bp_ready_ret", 32'(cmd_ready), 32'h1);
        tick();
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        check("bp_res3", 32'(res_data), 32'h03);
        for (int k = 4; k <= 6; k++) begin
            tick();
            check($sformatf("bp_res%0d", k), 32'(res_data), 32'(k));
            check($sformatf("bp_valid%0d", k), 32'(res_valid), 32'h1);
        end
        tick();
        check("bp_drained", 32'(res_valid), 32'h0);
        check("bp_acc",     32'(acc),       32'h06);

        // LOAD while a result is pending and unconsumed
        res_ready = 1'b0;
        drive(1'b1, 5'h01, 8'h00, 1'b0);
        tick();
        drive(1'b1, 5'h10, 8'h80, 1'b0);
        tick();
        check("ldp_res", 32'(res_data), 32'h07);
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        check("ldp_acc",   32'(acc),       32'h80);
        check("ldp_data",  32'(res_data),  32'h07);
        check("ldp_valid", 32'(res_valid), 32'h1);

        // Asynchronous reset with three queued commands and a pending result
        drive(1'b1, 5'h01, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        check("pre_rst_sel", 32'(alu_sel), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 32'h0);
        check("arst_data",  32'(res_data),  32'h00);
        check("arst_acc",   32'(acc),       32'h00);
        check("arst_ready", 32'(cmd_ready), 32'h1);
        check("arst_sel",   32'(alu_sel),   32'h0);
        check("arst_b",     32'(alu_b),     32'h00);
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(res_valid), 32'h0);
        check("post_rst_acc",   32'(acc),       32'h00);
        check("post_rst_sel",   32'(alu_sel),   32'h0);

`ifdef ALU_ISSUE_ZFLAG_EN
        drive(1'b1, 5'h10, 8'h01, 1'b0);
        tick();
        drive(1'b1, 5'h02, 8'h00, 1'b0);
        tick();
        drive(1'b1, 5'h01, 8'h00, 1'b0);
        tick();
        check("z_data", 32'(res_data), 32'h00);
        check("z_flag", 32'(res_zero), 32'h1);
        drive(1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        check("nz_data", 32'(res_data), 32'h01);
        check("nz_flag", 32'(res_zero), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
